imem_stim_sequencer: RTL and testbench



---
 rtl/imem_stim_sequencer_pkg.sv | 36 +++
 rtl/imem_stim_sequencer_lfsr.sv | 25 ++
 rtl/imem_stim_sequencer.sv | 134 +++++++++++++
 tb/tb_imem_stim_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_stim_sequencer_pkg.sv
// Shared constants, FSM state type and instruction-word helpers for the imem stimulus sequencer.
// Pure declarations: no latency, no flow control.
package sodor_stim_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;
  localparam logic [11:0] SHAMT_MASK_SR = 12'h41F;
  localparam logic [11:0] SHAMT_MASK_SL = 12'h01F;
  localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stim_state_e;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : 32'h0);
  endfunction

  // LFSR bits supply imm/rs1/funct3/rd in place; shift immediates are trimmed to legal shamt.
  function automatic logic [31:0] op_imm_word(input logic [31:0] l);
    logic [31:0] w;
    w = (l & 32'hFFFF_FF80) | {25'b0, OPC_OP_IMM};
    if (w[14:12] == 3'd5) begin
      w[31:20] = w[31:20] & SHAMT_MASK_SR;
    end else if (w[14:12] == 3'd1) begin
      w[31:20] = w[31:20] & SHAMT_MASK_SL;
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_stim_sequencer_lfsr.sv
// 32-bit Galois LFSR that loads its seed on reset and steps only when advance is high.
// One-cycle update latency; holds its state whenever advance is low.
module stim_lfsr32
  import sodor_stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= seed;
    end else if (advance) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/imem_stim_sequencer.sv
// Issues NOP flush, NUM_INSTR pseudo-random OP-IMM words, NOP drain over valid/ready, then signals done.
// Outputs decode registered state; a word holds while instr_valid && !instr_ready, next word the cycle after accept.
module imem_stim_sequencer
  import sodor_stim_pkg::*;
#(
  parameter int unsigned NUM_INSTR    = 100,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter logic [31:0] SEED         = 32'h0000_01B4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic [15:0] issued_cnt
);

  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] FLUSH_LAST  = 32'(FLUSH_CYCLES - 1);
  localparam logic [31:0] RUN_LAST    = 32'(NUM_INSTR - 1);
  localparam logic [31:0] DRAIN_LAST  = 32'(DRAIN_CYCLES - 1);
  localparam bit          SKIP_RUN    = (NUM_INSTR == 0);

  if (NUM_INSTR > 65535) begin : g_bad_num_instr
    $error("NUM_INSTR exceeds the 16-bit issued_cnt range");
  end
  if (FLUSH_CYCLES < 1 || DRAIN_CYCLES < 1) begin : g_bad_phase_len
    $error("FLUSH_CYCLES and DRAIN_CYCLES must be at least 1");
  end

  stim_state_e r_state, w_state_nxt;
  logic [31:0] r_phase_cnt, w_phase_cnt_nxt;
  logic [15:0] r_issued_cnt, w_issued_cnt_nxt;
  logic [31:0] w_lfsr_state;
  logic        w_accept;
  logic        w_lfsr_adv;

  assign w_accept   = instr_valid && instr_ready;
  assign w_lfsr_adv = (r_state == ST_RUN) && w_accept;
  assign issued_cnt = r_issued_cnt;

  stim_lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .seed    (SEED_EFF),
    .advance (w_lfsr_adv),
    .state   (w_lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_phase_cnt  <= '0;
      r_issued_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase_cnt  <= w_phase_cnt_nxt;
      r_issued_cnt <= w_issued_cnt_nxt;
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_FLUSH, ST_DRAIN: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      ST_RUN: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
        instr       = op_imm_word(w_lfsr_state);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // The phase counter is cleared on every phase exit so each phase counts its own accepts.
  always_comb begin
    w_state_nxt      = r_state;
    w_phase_cnt_nxt  = r_phase_cnt;
    w_issued_cnt_nxt = r_issued_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt      = ST_FLUSH;
          w_phase_cnt_nxt  = '0;
          w_issued_cnt_nxt = '0;
        end
      end
      ST_FLUSH: begin
        if (w_accept) begin
          if (r_phase_cnt == FLUSH_LAST) begin
            w_phase_cnt_nxt = '0;
            w_state_nxt     = SKIP_RUN ? ST_DRAIN : ST_RUN;
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + 32'd1;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_issued_cnt_nxt = r_issued_cnt + 16'd1;
          if (r_phase_cnt == RUN_LAST) begin
            w_phase_cnt_nxt = '0;
            w_state_nxt     = ST_DRAIN;
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + 32'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_accept) begin
          if (r_phase_cnt == DRAIN_LAST) begin
            w_phase_cnt_nxt = '0;
            w_state_nxt     = ST_DONE;
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + 32'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_stim_sequencer.sv
// Scoreboard bench for imem_stim_sequencer: default instance plus a NUM_INSTR=0 instance.
// Stimulus queues expected words; negedge monitors pop and compare on every accept.
module tb_imem_stim_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, start, instr_ready;
  logic        instr_valid, busy, done;
  logic [31:0] instr;
  logic [15:0] issued_cnt;

  logic        z_start, z_ready;
  logic        z_valid, z_busy, z_done;
  logic [31:0] z_instr;
  logic [15:0] z_issued;

  always #5 clk = ~clk;

  imem_stim_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .busy(busy), .done(done),
    .issued_cnt(issued_cnt)
  );

  imem_stim_sequencer #(.NUM_INSTR(0)) dut_zero (
    .clk(clk), .reset(reset), .start(z_start), .instr_ready(z_ready),
    .instr_valid(z_valid), .instr(z_instr), .busy(z_busy), .done(z_done),
    .issued_cnt(z_issued)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] z_exp_q[$];
  logic [31:0] cap[$];
  logic [31:0] run_a_cap[$];
  logic [31:0] run_a[$];
  logic [31:0] mdl;
  logic [31:0] held;
  bit          held_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference LFSR: taps of 0x80200003 toggled one by one after the shift.
  function automatic logic [31:0] m_step(input logic [31:0] l);
    logic [31:0] n;
    n = {1'b0, l[31:1]};
    if (l[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] l);
    logic [11:0] imm;
    logic [2:0]  f3;
    imm = l[31:20];
    f3  = l[14:12];
    if (f3 == 3'd5) imm = imm & 12'h41F;
    else if (f3 == 3'd1) imm = {7'b0, imm[4:0]};
    return {imm, l[19:15], f3, l[11:7], 7'b0010011};
  endfunction

  always @(negedge clk) begin
    if (held_vld && instr_valid) chk("stall_hold", instr, held);
    held_vld = instr_valid && !instr_ready;
    held     = instr;
    if (instr_valid && instr_ready && !reset) begin
      cap.push_back(instr);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %h expected no word", instr);
      end else begin
        chk("word", instr, exp_q.pop_front());
      end
      if (instr[14:12] == 3'd5) chk("srli_srai_imm_legal", {20'b0, instr[31:20] & 12'hBE0}, 32'd0);
      if (instr[14:12] == 3'd1) chk("slli_imm_legal", {25'b0, instr[31:25]}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (z_valid && z_ready && !reset) begin
      if (z_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL z_unexpected_word: got %h expected no word", z_instr);
      end else begin
        chk("z_word", z_instr, z_exp_q.pop_front());
      end
    end
  end

  task automatic push_nops(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(NOP);
  endtask

  task automatic push_run_a(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(run_a[i]);
  endtask

  task automatic run_to_done(input bit toggle, input int pulse_at, input int budget, output int cycles);
    cycles      = 0;
    start       = 1'b1;
    instr_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
      if (cycles == 1) begin
        chk("start_clears_issued", {16'b0, issued_cnt}, 32'd0);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
      end
      if (cycles == pulse_at) start = 1'b1;
      if (toggle) instr_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
    end while (!done && cycles < budget);
    if (!done) begin
      n_total++;
      $display("FAIL done_timeout: done still 0 after %0d cycles", cycles);
    end
    instr_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int mism;
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
    z_start = 1'b0; z_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", {31'b0, instr_valid}, 32'd0);
      chk("idle_instr", instr, NOP);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_issued", {16'b0, issued_cnt}, 32'd0);
    end

    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("reset_beats_start_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_beats_start_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0; start = 1'b0;

    // Run A: continuous ready, spurious start mid-run must be ignored.
    mdl = 32'h0000_01B4;
    for (int i = 0; i < 100; i++) begin
      run_a.push_back(m_word(mdl));
      mdl = m_step(mdl);
    end
    push_nops(3); push_run_a(100); push_nops(5);
    cap.delete();
    run_to_done(1'b0, 50, 500, cyc);
    chk("runA_done_cycle", cyc, 109);
    chk("runA_issued", {16'b0, issued_cnt}, 32'd100);
    chk("runA_queue_empty", exp_q.size(), 0);
    chk("runA_word_count", cap.size(), 108);
    chk("runA_word0", cap[3], 32'h0000_0193);
    chk("runA_word1", cap[4], 32'h0000_0093);
    chk("runA_word2", cap[5], 32'h0000_0013);
    chk("runA_word3", cap[6], 32'h8020_0013);
    chk("runA_busy_at_done", {31'b0, busy}, 32'd0);
    run_a_cap = cap;

    // Run B: ready toggling 1,0,0,1 after reseed.
    pulse_reset();
    push_nops(3); push_run_a(100); push_nops(5);
    cap.delete();
    run_to_done(1'b1, -1, 2000, cyc);
    chk("runB_issued", {16'b0, issued_cnt}, 32'd100);
    chk("runB_queue_empty", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 108; i++) if (i >= cap.size() || cap[i] !== run_a_cap[i]) mism++;
    chk("runB_identical_mismatches", mism, 0);

    // NUM_INSTR=0 instance: 3 + 5 NOPs then done.
    for (int i = 0; i < 8; i++) z_exp_q.push_back(NOP);
    z_start = 1'b1; z_ready = 1'b1; cyc = 0;
    do begin
      @(posedge clk); #1;
      z_start = 1'b0;
      cyc++;
    end while (!z_done && cyc < 100);
    chk("zero_done_cycle", cyc, 9);
    chk("zero_issued", {16'b0, z_issued}, 32'd0);
    chk("zero_queue_empty", z_exp_q.size(), 0);

    // Run C: reset after 40 RUN accepts, then full replay.
    pulse_reset();
    push_nops(3); push_run_a(40);
    start = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("runC_issued_before_reset", {16'b0, issued_cnt}, 32'd40);
    chk("runC_queue_empty_40", exp_q.size(), 0);
    instr_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("runC_reset_issued", {16'b0, issued_cnt}, 32'd0);
    chk("runC_reset_valid", {31'b0, instr_valid}, 32'd0);
    push_nops(3); push_run_a(100); push_nops(5);
    cap.delete();
    run_to_done(1'b0, -1, 500, cyc);
    chk("runC_replay_issued", {16'b0, issued_cnt}, 32'd100);
    chk("runC_replay_queue_empty", exp_q.size(), 0);

    // Run D: restart from DONE, LFSR continues from where run C left it.
    push_nops(3);
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(m_word(mdl));
      mdl = m_step(mdl);
    end
    push_nops(5);
    cap.delete();
    run_to_done(1'b0, -1, 500, cyc);
    chk("runD_done_cycle", cyc, 109);
    chk("runD_issued", {16'b0, issued_cnt}, 32'd100);
    chk("runD_queue_empty", exp_q.size(), 0);
    chk("runD_first_word_differs", {31'b0, cap.size() > 3 && cap[3] !== run_a_cap[3]}, 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
